// File: rtl/rf_restore.sv
// rf_restore: lockstep-error register-file recovery sequencer.
//
// On a comparator mismatch it halts both cores, waits until they report
// halted and drained, copies shadow GPRs 1..NUM_REGS-1 into both register
// files (one register per cycle), writes the saved safe PC, and then
// releases the cores with a one-cycle done pulse. An error that arrives
// while a recovery is already running is remembered. The FSM runs a second
// full recovery straight after the first one.
//
// Optional feature, enabled by defining the macro RF_RESTORE_TIMEOUT_EN:
// a halt-wait watchdog. If the cores do not report halted within
// TIMEOUT_CYCLES cycles of HALT, the FSM parks in a sticky FAIL state.
// Only rst_i can leave that state. With the macro undefined, HALT waits
// forever and fail_o is tied low.
module rf_restore #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  error_i,
    input  logic                  core_halted_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [DATA_WIDTH-1:0] spc_i,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    output logic                  halt_req_o,
    output logic                  core_we_o,
    output logic [ADDR_WIDTH-1:0] core_waddr_o,
    output logic [DATA_WIDTH-1:0] core_wdata_o,
    output logic                  core_pc_we_o,
    output logic [DATA_WIDTH-1:0] core_pc_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o
);

    // Elaboration guard: at least one restorable register, and the last
    // restored address must fit the address width.
    if (NUM_REGS < 2 || NUM_REGS > (1 << ADDR_WIDTH) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("rf_restore: illegal NUM_REGS / ADDR_WIDTH / TIMEOUT_CYCLES");
    end

    // Register 0 is hard-wired zero in the cores, so the copy starts at 1.
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HALT    = 3'd1,
        S_RESTORE = 3'd2,
        S_PC      = 3'd3,
        S_RESUME  = 3'd4
`ifdef RF_RESTORE_TIMEOUT_EN
        ,
        S_FAIL    = 3'd5
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    pending_q, pending_d;
    logic                    halt_req_q, halt_req_d;

`ifdef RF_RESTORE_TIMEOUT_EN
    localparam int HALT_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [HALT_CNT_W-1:0] HALT_LAST = HALT_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HALT_CNT_W-1:0] HALT_ONE  = HALT_CNT_W'(1);

    logic [HALT_CNT_W-1:0]   halt_cnt_q, halt_cnt_d;
`endif

    // Next-state, next-address, pending-error and halt-request logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        addr_d    = '0;
        pending_d = pending_q;

        case (state_q)
            S_IDLE: begin
                if (error_i) begin
                    state_d = S_HALT;
                end
            end

            S_HALT: begin
                pending_d = pending_q | error_i;
                if (core_halted_i) begin
                    state_d = S_RESTORE;
                    addr_d  = FIRST_ADDR;
                end
`ifdef RF_RESTORE_TIMEOUT_EN
                else if (halt_cnt_q == HALT_LAST) begin
                    state_d = S_FAIL;
                end
`endif
            end

            // core_halted_i is deliberately not looked at from here on: once
            // the copy has started it always runs to completion.
            S_RESTORE: begin
                pending_d = pending_q | error_i;
                if (addr_q == LAST_ADDR) begin
                    state_d = S_PC;
                end else begin
                    addr_d = addr_q + FIRST_ADDR;
                end
            end

            S_PC: begin
                pending_d = pending_q | error_i;
                state_d   = S_RESUME;
            end

            // An error still outstanding at this point restarts recovery
            // immediately. The done pulse for this pass is still given.
            S_RESUME: begin
                pending_d = 1'b0;
                state_d   = (pending_q || error_i) ? S_HALT : S_IDLE;
            end

`ifdef RF_RESTORE_TIMEOUT_EN
            // Sticky: errors are ignored and only reset leaves FAIL.
            S_FAIL: begin
                state_d = S_FAIL;
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

        halt_req_d = (state_d == S_HALT) || (state_d == S_RESTORE) || (state_d == S_PC);
`ifdef RF_RESTORE_TIMEOUT_EN
        if (state_d == S_FAIL) begin
            halt_req_d = 1'b1;
        end
`endif
    end

    // State, address counter, pending flag and registered halt request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples the values that were present before the edge.
        if (rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            pending_q  <= 1'b0;
            halt_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pending_q  <= pending_d;
            halt_req_q <= halt_req_d;
        end
    end

`ifdef RF_RESTORE_TIMEOUT_EN
    // Halt-wait count: number of HALT cycles spent so far in this HALT visit.
    always_comb begin
        halt_cnt_d = '0;
        if (state_q == S_HALT && state_d == S_HALT) begin
            halt_cnt_d = halt_cnt_q + HALT_ONE;
        end
    end

    // Halt-wait counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            halt_cnt_q <= '0;
        end else begin
            halt_cnt_q <= halt_cnt_d;
        end
    end

    assign fail_o = (state_q == S_FAIL);
`else
    assign fail_o = 1'b0;
`endif

    // The write ports are decoded from the state alone. They are zeroed
    // outside their own state, so reset forces them low immediately.
    assign raddr_o      = addr_q;
    assign halt_req_o   = halt_req_q;
    assign core_we_o    = (state_q == S_RESTORE);
    assign core_waddr_o = core_we_o ? addr_q : '0;
    assign core_wdata_o = core_we_o ? rdata_i : '0;
    assign core_pc_we_o = (state_q == S_PC);
    assign core_pc_o    = core_pc_we_o ? spc_i : '0;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_RESUME);

endmodule

// File: doc/rf_restore.md
RF_RESTORE -- requirements
Module: rf_restore

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register address width.
REQ-002 Parameter DATA_WIDTH, default 32, register and PC data width.
REQ-003 Parameter NUM_REGS, default 32, registers restored; SHALL be ≤ 2**ADDR_WIDTH and ≥ 2.
REQ-004 Parameter TIMEOUT_CYCLES, default 256, halt-wait limit (used only under RF_RESTORE_TIMEOUT_EN).
REQ-005 Clocking SHALL be exactly: one clock, clk_i; reset rst_i, asynchronous, active-high.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_i  in  1  async active-high reset.
REQ-008 error_i  in  1  lockstep mismatch from the comparator, high = error.
REQ-009 core_halted_i  in  1  both cores halted and pipelines drained.
REQ-010 rdata_i  in  DATA_WIDTH  shadow-GPR read data, combinational from raddr_o.
REQ-011 spc_i  in  DATA_WIDTH  saved safe PC from the shadow-PC stage.
REQ-012 raddr_o  out  ADDR_WIDTH  shadow-GPR read address.
REQ-013 halt_req_o  out  1  halt request to both cores.
REQ-014 core_we_o / core_waddr_o / core_wdata_o  out  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port to both cores.
REQ-015 core_pc_we_o / core_pc_o  out  1 / DATA_WIDTH  PC write to both cores.
REQ-016 busy_o  out  1  high in any state other than IDLE.
REQ-017 done_o  out  1  one-cycle pulse on recovery completion.
REQ-018 fail_o  out  1  sticky halt-timeout flag.

Function
REQ-019 FSM states: IDLE, HALT, RESTORE, PC, RESUME, FAIL; state, counter and halt_req_o SHALL be registered.
REQ-020 IDLE: error_i=1 at edge N -> HALT at N+1; halt_req_o high from N+1.
REQ-021 HALT: halt_req_o=1; core_halted_i=1 at an edge -> RESTORE next cycle with raddr_o=1.
REQ-022 RESTORE: core_we_o=1, core_waddr_o=raddr_o, core_wdata_o=rdata_i, combinational in the same cycle; raddr_o increments by 1 per cycle.
REQ-023 Address 0 SHALL never be written; RESTORE lasts exactly NUM_REGS-1 cycles, last address NUM_REGS-1, then PC.
REQ-024 PC: exactly one cycle, core_pc_we_o=1, core_pc_o=spc_i; core_we_o=0; then RESUME.
REQ-025 RESUME: halt_req_o=0, done_o=1 for exactly that cycle; next state IDLE.
REQ-026 core_we_o and core_pc_we_o SHALL never be high in the same cycle, and SHALL be 0 outside RESTORE and PC respectively.
REQ-027 error_i high while busy_o=1 SHALL set a pending flag; from RESUME the FSM enters HALT instead of IDLE if pending is set (pending cleared on that entry); done_o still pulses.
REQ-028 core_halted_i dropping during RESTORE or PC SHALL be ignored; sequence completes.
REQ-029 raddr_o SHALL be 0 outside RESTORE and SHALL not wrap within a sequence.

Reset
REQ-030 rst_i asserted SHALL immediately force IDLE, counters 0, pending 0, fail_o 0.
REQ-031 All outputs SHALL be 0 during and directly after reset; reset mid-RESTORE SHALL abort with no further core writes.

Configuration
REQ-032 Macro RF_RESTORE_TIMEOUT_EN defined: a halt-wait counter SHALL run in HALT; if core_halted_i remains 0 for TIMEOUT_CYCLES cycles, next state FAIL.
REQ-033 FAIL: fail_o=1, halt_req_o=1, all write enables 0, error_i ignored; exit only via rst_i.
REQ-034 Macro undefined: HALT waits indefinitely, FAIL state and counter absent, fail_o tied 0.

Verification
REQ-035 Single error: error_i pulse at cycle 10, core_halted_i at 14 -> halt_req_o 11..46, core writes addr 1..31 cycles 15..45, pc write cycle 46 with spc_i=0x0000_0080, done_o at 47.
REQ-036 Data integrity: shadow GPR preloaded x[i]=0xA5A5_0000+i -> core write stream equals these values, addr 0 never written.
REQ-037 Error during RESTORE at addr 7 -> sequence completes, done_o pulse, HALT re-entered next cycle, second full restore.
REQ-038 rst_i at raddr_o=12 -> all outputs 0 same cycle, IDLE, no write to addr 13.
REQ-039 RF_RESTORE_TIMEOUT_EN, TIMEOUT_CYCLES=8, core_halted_i held 0 -> fail_o high after 8 HALT cycles, stays high, later error_i ignored.
REQ-040 Macro undefined, core_halted_i held 0 for 1000 cycles -> stays HALT, fail_o=0, no writes.
